// File: rtl/bin_normalizer.sv
// bin_normalizer
//
// Sits downstream of the pixel binner. Each time the binner completes an
// output row, the row's 16-bit R/G/B bin sums are read out of the binner's
// inactive buffer set, one column per cycle. Each sum is scaled to an 8-bit
// channel value and the packed pixels are written into the classifier frame
// RAM. frame_done pulses with the final write of the last row.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   r_data/g_data/b_data    binner bin sums, indexed [set][col]
//   row_i                   binner completed-row counter (0..ROWS)
//   pxl_idle_i              binner idle flag; its falling edge starts a frame
//   wr_en/wr_addr/wr_data   frame RAM write port, addr = {row, col}
//   busy                    a row is being read out
//   frame_done              one-cycle pulse with the last write of row ROWS-1
//   overrun                 sticky, a row event was dropped
module bin_normalizer #(
    parameter int COLS    = 32,
    parameter int ROWS    = 32,
    parameter int K_SCALE = 38336,
    parameter int SHIFT   = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0][COLS-1:0][15:0]  r_data,
    input  logic [1:0][COLS-1:0][15:0]  g_data,
    input  logic [1:0][COLS-1:0][15:0]  b_data,
    input  logic [5:0]                  row_i,
    input  logic                        pxl_idle_i,
    output logic                        wr_en,
    output logic [9:0]                  wr_addr,
    output logic [23:0]                 wr_data,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overrun
);

    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t      r_state;
    logic [5:0]  r_row_q;
    logic        r_set_ptr;
    logic        r_pending;
    logic [4:0]  r_pend_row;
    logic        r_pend_set;
    logic [4:0]  r_rd_row;
    logic        r_rd_set;
    logic [4:0]  r_col;
    logic        r_idle_q;

    logic        r_vld_p1;
    logic        r_last_p1;
    logic [4:0]  r_row_p1;
    logic [4:0]  r_col_p1;
    logic [31:0] r_prod_r_p1;
    logic [31:0] r_prod_g_p1;
    logic [31:0] r_prod_b_p1;

    logic        w_fstart;
    logic        w_evt;
    logic [4:0]  w_evt_row;
    logic        w_last_col;
    logic        w_drained;
    logic        w_launch_evt;
    logic        w_start_pend;
    logic [15:0] w_sum_r;
    logic [15:0] w_sum_g;
    logic [15:0] w_sum_b;

    function automatic logic [7:0] sat_u8(input logic [31:0] prod);
        logic [31:0] v;
        v = prod >> SHIFT;
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    assign w_fstart   = r_idle_q & ~pxl_idle_i;
    // A frame start takes priority: the counter is being reset, so a
    // simultaneous row_i change is not treated as a row event.
    assign w_evt      = (row_i != r_row_q) && (row_i != 6'd0) && !w_fstart;
    assign w_evt_row  = 5'(row_i - 6'd1);
    assign w_last_col = (r_col == LAST_COL);
    assign w_drained  = !r_vld_p1 && !wr_en;

    assign w_launch_evt = (r_state == S_IDLE) && w_evt;
    // The pipeline is strictly in order, so a pending row may start the cycle
    // after the previous row's last column; this keeps writes back-to-back.
    assign w_start_pend = r_pending &&
                          (((r_state == S_IDLE) && !w_evt) ||
                           ((r_state == S_RUN) && w_last_col) ||
                           (r_state == S_DRAIN));

    // Control: row tracking, row sequencing, pending/overrun bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_row_q    <= '0;
            r_set_ptr  <= 1'b0;
            r_pending  <= 1'b0;
            r_pend_row <= '0;
            r_pend_set <= 1'b0;
            r_rd_row   <= '0;
            r_rd_set   <= 1'b0;
            r_col      <= '0;
            r_idle_q   <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_idle_q <= pxl_idle_i;
            if (w_fstart) begin
                r_state   <= S_IDLE;
                r_row_q   <= '0;
                r_set_ptr <= 1'b0;
                r_pending <= 1'b0;
                r_col     <= '0;
                busy      <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                if (w_evt) begin
                    r_row_q   <= row_i;
                    r_set_ptr <= ~r_set_ptr;
                end

                if (w_launch_evt || w_start_pend) begin
                    r_state  <= S_RUN;
                    r_col    <= '0;
                    busy     <= 1'b1;
                    r_rd_row <= w_launch_evt ? w_evt_row : r_pend_row;
                    r_rd_set <= w_launch_evt ? r_set_ptr : r_pend_set;
                    if (w_start_pend) begin
                        r_pending <= 1'b0;
                    end
                end else begin
                    case (r_state)
                        S_RUN: begin
                            if (w_last_col) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_col <= r_col + 5'd1;
                            end
                        end
                        S_DRAIN: begin
                            if (w_drained) begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end

                // Event while a row is in flight: queue one, drop any further.
                // A pending row being launched this cycle frees the slot.
                if ((r_state != S_IDLE) && w_evt) begin
                    if (r_pending && !w_start_pend) begin
                        overrun <= 1'b1;
                    end else begin
                        r_pend_row <= w_evt_row;
                        r_pend_set <= r_set_ptr;
                        r_pending  <= 1'b1;
                    end
                end
            end
        end
    end

    // S0: combinational read of the selected set/column.
    assign w_sum_r = r_data[r_rd_set][r_col];
    assign w_sum_g = g_data[r_rd_set][r_col];
    assign w_sum_b = b_data[r_rd_set][r_col];

    // S1: unsigned products and the address tag travelling with them.
    always_ff @(posedge clk) begin
        r_prod_r_p1 <= {16'd0, w_sum_r} * 32'(K_SCALE);
        r_prod_g_p1 <= {16'd0, w_sum_g} * 32'(K_SCALE);
        r_prod_b_p1 <= {16'd0, w_sum_b} * 32'(K_SCALE);
        r_row_p1    <= r_rd_row;
        r_col_p1    <= r_col;
        r_last_p1   <= (r_rd_row == LAST_ROW) && w_last_col;
    end

    // S2: shift, saturate and register the RAM write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else if (w_fstart) begin
            r_vld_p1   <= 1'b0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_vld_p1   <= (r_state == S_RUN);
            wr_en      <= r_vld_p1;
            frame_done <= r_vld_p1 && r_last_p1;
            if (r_vld_p1) begin
                wr_addr <= {r_row_p1, r_col_p1};
                wr_data <= {sat_u8(r_prod_r_p1), sat_u8(r_prod_g_p1), sat_u8(r_prod_b_p1)};
            end
        end
    end

endmodule

// File: tb/tb_bin_normalizer.sv
module tb_bin_normalizer;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [1:0][31:0][15:0]  r_data;
    logic [1:0][31:0][15:0]  g_data;
    logic [1:0][31:0][15:0]  b_data;
    logic [5:0]              row_i;
    logic                    pxl_idle_i;
    logic                    wr_en;
    logic [9:0]              wr_addr;
    logic [23:0]             wr_data;
    logic                    busy;
    logic                    frame_done;
    logic                    overrun;

    bin_normalizer dut (
        .clk        (clk),
        .reset      (reset),
        .r_data     (r_data),
        .g_data     (g_data),
        .b_data     (b_data),
        .row_i      (row_i),
        .pxl_idle_i (pxl_idle_i),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0]  addr;
        logic [23:0] data;
        int unsigned cyc;
        logic        fd;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_fd = 0;

    // Hand-computed pixel values per test pattern.
    //   6975->FF, 3488->7F, 9000->FF (sat), 0->00, 1000->24, 2000->49, 4000->92
    function automatic logic [23:0] data_of(input int mode, input int col);
        case (mode)
            0: return 24'hFFFFFF;
            1: return 24'h007FFF;
            2: return (col == 5) ? 24'h7F7F00 : 24'hFF7F00;
            3: return (col == 31) ? 24'h244900 : 24'h244992;
            default: return 24'h7F7F7F;
        endcase
    endfunction

    task automatic push_row(input int row, input int unsigned t0, input int ncols, input int mode);
        exp_t x;
        for (int c = 0; c < ncols; c++) begin
            x.addr = 10'(row * 32 + c);
            x.data = data_of(mode, c);
            x.cyc  = t0 + c;
            x.fd   = (row == 31) && (c == 31);
            q.push_back(x);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitn(input int n);
        repeat (n) tick();
    endtask

    task automatic set_all(input int s, input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
        for (int c = 0; c < 32; c++) begin
            r_data[s][c] = r;
            g_data[s][c] = g;
            b_data[s][c] = b;
        end
    endtask

    task automatic frame_start();
        row_i = 6'd0;
        pxl_idle_i = 1'b1;
        tick();
        pxl_idle_i = 1'b0;
        tick();
        tick();
    endtask

    // Scoreboard monitor: every write is matched against the next expected entry.
    always @(negedge clk) begin
        if (wr_en) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%0h data=%0h cyc=%0d", wr_addr, wr_data, cyc);
            end else begin
                e = q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data || cyc !== e.cyc || frame_done !== e.fd) begin
                    n_fail++;
                    $display("FAIL write got addr=%0h data=%0h cyc=%0d fd=%0b exp addr=%0h data=%0h cyc=%0d fd=%0b",
                             wr_addr, wr_data, cyc, frame_done, e.addr, e.data, e.cyc, e.fd);
                end
            end
            if (frame_done) n_fd++;
        end else if (frame_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_done_without_write cyc=%0d", cyc);
        end
    end

    initial begin
        int unsigned t;
        int fd0;
        row_i = 6'd0;
        pxl_idle_i = 1'b0;
        set_all(0, 16'd6975, 16'd6975, 16'd6975);
        set_all(1, 16'd6975, 16'd6975, 16'd6975);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        waitn(2);

        // First row: full scale, latency and busy window
        row_i = 6'd1;
        t = cyc;
        push_row(0, t + 3, 32, 0);
        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            chk("busy_window", busy, (cyc >= t + 1 && cyc <= t + 35) ? 1 : 0);
        end
        waitn(5);

        // Zero / mid / saturating channels
        frame_start();
        set_all(0, 16'd0, 16'd3488, 16'd9000);
        row_i = 6'd1;
        t = cyc;
        push_row(0, t + 3, 32, 1);
        waitn(40);

        // Full frame, alternating buffer sets
        frame_start();
        set_all(0, 16'd6975, 16'd3488, 16'd0);
        r_data[0][5] = 16'd3488;
        set_all(1, 16'd1000, 16'd2000, 16'd4000);
        b_data[1][31] = 16'd0;
        fd0 = n_fd;
        for (int k = 1; k <= 32; k++) begin
            row_i = 6'(k);
            t = cyc;
            push_row(k - 1, t + 3, 32, ((k - 1) % 2 == 1) ? 3 : 2);
            waitn(50);
        end
        chk("frame_done_count", n_fd - fd0, 1);
        chk("frame_overrun", overrun, 0);

        // Back-to-back rows and a dropped third event
        frame_start();
        set_all(0, 16'd6975, 16'd6975, 16'd6975);
        set_all(1, 16'd3488, 16'd3488, 16'd3488);
        row_i = 6'd1;
        t = cyc;
        push_row(0, t + 3, 32, 0);
        waitn(2);
        row_i = 6'd2;
        push_row(1, t + 35, 32, 4);
        waitn(8);
        row_i = 6'd3;
        waitn(80);
        chk("overrun_set", overrun, 1);

        // Frame start aborts an in-flight row
        row_i = 6'd4;
        t = cyc;
        push_row(3, t + 3, 4, 4);
        waitn(5);
        pxl_idle_i = 1'b1;
        row_i = 6'd0;
        tick();
        pxl_idle_i = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun, 0);
        waitn(10);
        row_i = 6'd1;
        t = cyc;
        push_row(0, t + 3, 32, 0);
        waitn(40);

        // Asynchronous reset mid-row
        row_i = 6'd2;
        t = cyc;
        push_row(1, t + 3, 5, 4);
        waitn(8);
        reset = 1'b1;
        row_i = 6'd0;
        #1;
        chk("async_rst_wr_en", wr_en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_wr_data", wr_data, 0);
        waitn(2);
        reset = 1'b0;
        waitn(40);
        chk("post_rst_busy", busy, 0);
        row_i = 6'd1;
        t = cyc;
        push_row(0, t + 3, 32, 0);
        waitn(40);

        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
